// File: rtl/bitstream_pkg.sv
// Shared types and constants for the stochastic bitstream decoder.
// Holds the output-register FSM encoding and the default window width.
package bitstream_pkg;

    localparam int BS_WINDOW_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/bitstream_decoder_if.sv
// Sample input and valid/ready result bundle of the bitstream decoder.
// The overrun flag exists only with BITSTREAM_DECODER_OVERRUN_EN.
interface bitstream_decoder_if
    import bitstream_pkg::*;
    #(parameter int WIDTH = BS_WINDOW_W);

    logic           x;
    logic           en;
    logic [WIDTH:0] y;
    logic           y_valid;
    logic           y_ready;
`ifdef BITSTREAM_DECODER_OVERRUN_EN
    logic           overrun;

    modport slave (
        input  x, en, y_ready,
        output y, y_valid, overrun
    );

    modport master (
        output x, en, y_ready,
        input  y, y_valid, overrun
    );
`else
    modport slave (
        input  x, en, y_ready,
        output y, y_valid
    );

    modport master (
        output x, en, y_ready,
        input  y, y_valid
    );
`endif

endinterface

// File: rtl/bitstream_decoder_window_counter.sv
// Counts qualified samples and ones over a 2^WIDTH sample window.
// done/count are combinational so the result lands on the final sample edge.
module window_counter
    import bitstream_pkg::*;
    #(parameter int WIDTH = BS_WINDOW_W) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_x,
    input  logic           i_en,
    output logic           o_done,
    output logic [WIDTH:0] o_count
);

    logic [WIDTH-1:0] r_sample_cnt;
    logic [WIDTH:0]   r_ones_cnt;
    logic             w_last;
    logic [WIDTH:0]   w_x_ext;

    assign w_last  = (r_sample_cnt == '1);
    assign w_x_ext = {{WIDTH{1'b0}}, i_x};
    assign o_done  = i_en & w_last;
    assign o_count = r_ones_cnt + w_x_ext;

    // Advance the window on qualified samples; restart with no gap on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
        end else if (i_en) begin
            r_sample_cnt <= r_sample_cnt + WIDTH'(1);
            if (w_last)
                r_ones_cnt <= '0;
            else
                r_ones_cnt <= r_ones_cnt + w_x_ext;
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream to binary decoder with a valid/ready result register.
// Define BITSTREAM_DECODER_OVERRUN_EN to add the sticky overrun flag.
module bitstream_decoder
    import bitstream_pkg::*;
    #(parameter int WIDTH = BS_WINDOW_W) (
    input  logic                clk,
    input  logic                rst,
    bitstream_decoder_if.slave  bus
);

    logic           w_done;
    logic [WIDTH:0] w_count;

    out_state_t     r_state;
    logic [WIDTH:0] r_y;
    logic           r_y_valid;
`ifdef BITSTREAM_DECODER_OVERRUN_EN
    logic           r_overrun;
`endif

    window_counter #(.WIDTH(WIDTH)) u_window (
        .clk     (clk),
        .rst     (rst),
        .i_x     (bus.x),
        .i_en    (bus.en),
        .o_done  (w_done),
        .o_count (w_count)
    );

    // Output register: load on completion, drop new results while blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_y       <= '0;
            r_y_valid <= 1'b0;
`ifdef BITSTREAM_DECODER_OVERRUN_EN
            r_overrun <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_done) begin
                        r_y       <= w_count;
                        r_y_valid <= 1'b1;
                        r_state   <= FULL;
                    end
                end
                FULL: begin
                    if (bus.y_ready) begin
                        if (w_done) begin
                            r_y <= w_count;
                        end else begin
                            r_y_valid <= 1'b0;
                            r_state   <= EMPTY;
                        end
                    end else if (w_done) begin
`ifdef BITSTREAM_DECODER_OVERRUN_EN
                        r_overrun <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state   <= EMPTY;
                    r_y_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
`ifdef BITSTREAM_DECODER_OVERRUN_EN
    assign bus.overrun = r_overrun;
`endif

endmodule

// File: tb/tb_bitstream_decoder.sv
// Self-checking bench for bitstream_decoder with 16-sample windows.
// Reference model collects window samples in a queue and sums them.
module tb_bitstream_decoder;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bitstream_decoder_if #(.WIDTH(W)) bus ();

    bitstream_decoder #(.WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit         win[$];
    logic [W:0] m_y;
    bit         m_valid;
    bit         m_over;

    task automatic model_clear();
        win.delete();
        m_y     = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        bus.x       = 1'b0;
        bus.en      = 1'b0;
        bus.y_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input bit xi, input bit ei, input bit ri);
        int  res;
        bit  done;
        bit  xfer;
        bus.x       = xi;
        bus.en      = ei;
        bus.y_ready = ri;
        @(posedge clk);
        done = 1'b0;
        res  = 0;
        if (ei) begin
            win.push_back(xi);
            if (win.size() == N) begin
                foreach (win[k]) res += int'(win[k]);
                win.delete();
                done = 1'b1;
            end
        end
        xfer = m_valid && ri;
        if (done) begin
            if (!m_valid || xfer) begin
                m_y     = res[W:0];
                m_valid = 1'b1;
            end else begin
                m_over = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.y_valid !== 1'b0 || bus.y !== '0)
            $display("FAIL reset_hold: y=%0d v=%b want 0/0", bus.y, bus.y_valid);
        else
            n_pass++;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 1'b1);
            n_checks++;
            if (bus.y_valid !== 1'b0 || bus.y !== '0)
                $display("FAIL reset_idle c%0d: y=%0d v=%b want 0/0",
                         c, bus.y, bus.y_valid);
            else
                n_pass++;
        end
    endtask

    task automatic test_all_ones();
        apply_reset();
        for (int c = 0; c < N; c++) begin
            step(1'b1, 1'b1, 1'b1);
            n_checks++;
            if (bus.y_valid !== m_valid || bus.y !== m_y)
                $display("FAIL ones c%0d: y=%0d v=%b want %0d/%b",
                         c, bus.y, bus.y_valid, m_y, m_valid);
            else
                n_pass++;
        end
        n_checks++;
        if (bus.y !== 5'd16 || bus.y_valid !== 1'b1)
            $display("FAIL ones_result: y=%0d v=%b want 16/1",
                     bus.y, bus.y_valid);
        else
            n_pass++;
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus.y_valid !== 1'b0)
            $display("FAIL ones_onecycle: v=%b want 0", bus.y_valid);
        else
            n_pass++;
    endtask

    task automatic test_alternating();
        apply_reset();
        for (int c = 0; c < 2 * N; c++) begin
            step((c % 4) == 1, (c % 2) == 1, 1'b1);
            n_checks++;
            if (bus.y_valid !== m_valid || bus.y !== m_y)
                $display("FAIL alt c%0d: y=%0d v=%b want %0d/%b",
                         c, bus.y, bus.y_valid, m_y, m_valid);
            else
                n_pass++;
        end
        n_checks++;
        if (bus.y !== 5'd8 || bus.y_valid !== 1'b1)
            $display("FAIL alt_result: y=%0d v=%b want 8/1",
                     bus.y, bus.y_valid);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 2 * N + 1; c++) begin
            step(c < N, c < 2 * N, 1'b1);
            n_checks++;
            if (bus.y_valid !== m_valid || bus.y !== m_y)
                $display("FAIL b2b c%0d: y=%0d v=%b want %0d/%b",
                         c, bus.y, bus.y_valid, m_y, m_valid);
            else
                n_pass++;
            if (c == N - 1) begin
                n_checks++;
                if (bus.y !== 5'd16 || bus.y_valid !== 1'b1)
                    $display("FAIL b2b_first: y=%0d v=%b want 16/1",
                             bus.y, bus.y_valid);
                else
                    n_pass++;
            end
            if (c == 2 * N - 1) begin
                n_checks++;
                if (bus.y !== 5'd0 || bus.y_valid !== 1'b1)
                    $display("FAIL b2b_second: y=%0d v=%b want 0/1",
                             bus.y, bus.y_valid);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int c = 0; c < 2 * N; c++) begin
            step((c < 5) || (c >= N && c < N + 9), 1'b1, 1'b0);
            n_checks++;
            if (bus.y_valid !== m_valid || bus.y !== m_y)
                $display("FAIL bp c%0d: y=%0d v=%b want %0d/%b",
                         c, bus.y, bus.y_valid, m_y, m_valid);
            else
                n_pass++;
        end
        n_checks++;
        if (bus.y !== 5'd5 || bus.y_valid !== 1'b1)
            $display("FAIL bp_hold: y=%0d v=%b want 5/1",
                     bus.y, bus.y_valid);
        else
            n_pass++;
`ifdef BITSTREAM_DECODER_OVERRUN_EN
        n_checks++;
        if (bus.overrun !== 1'b1)
            $display("FAIL bp_overrun: ov=%b want 1", bus.overrun);
        else
            n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < N + 10; c++)
            step(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        model_clear();
        n_checks++;
        if (bus.y_valid !== 1'b0 || bus.y !== '0)
            $display("FAIL mid_async: y=%0d v=%b want 0/0",
                     bus.y, bus.y_valid);
        else
            n_pass++;
        #1;
        rst = 1'b0;
        for (int c = 0; c < N; c++) begin
            step(1'b1, 1'b1, 1'b0);
            n_checks++;
            if (bus.y_valid !== m_valid || bus.y !== m_y)
                $display("FAIL mid c%0d: y=%0d v=%b want %0d/%b",
                         c, bus.y, bus.y_valid, m_y, m_valid);
            else
                n_pass++;
        end
        n_checks++;
        if (bus.y !== 5'd16 || bus.y_valid !== 1'b1)
            $display("FAIL mid_result: y=%0d v=%b want 16/1",
                     bus.y, bus.y_valid);
        else
            n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0);
            n_checks++;
            if (bus.y_valid !== m_valid || bus.y !== m_y)
                $display("FAIL rand c%0d: y=%0d v=%b want %0d/%b",
                         c, bus.y, bus.y_valid, m_y, m_valid);
            else
                n_pass++;
`ifdef BITSTREAM_DECODER_OVERRUN_EN
            n_checks++;
            if (bus.overrun !== m_over)
                $display("FAIL rand_ov c%0d: ov=%b want %b",
                         c, bus.overrun, m_over);
            else
                n_pass++;
`endif
        end
    endtask

    initial begin
        bus.x       = 1'b0;
        bus.en      = 1'b0;
        bus.y_ready = 1'b0;
        model_clear();
        test_reset();
        test_all_ones();
        test_alternating();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bitstream_decoder.md
# bitstream_decoder

Converts a unipolar stochastic bitstream back to a binary value by counting ones over a fixed window of 2^WIDTH valid samples. It sits directly downstream of the sigmoid stage and consumes its single-bit output `y`. It hands the count to binary logic through a valid/ready register. Accumulation of the next window continues while a result waits to be taken.

## Interface
- `WIDTH`, default 8: window length is 2^WIDTH samples; the result is WIDTH+1 bits wide so that an all-ones window (2^WIDTH) is representable.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `x`  in  1  bitstream sample (sigmoid output).
- `en`  in  1  sample qualifier; `x` is counted only on cycles with `en`=1.
- `y`  out  WIDTH+1  ones-count of the last completed window.
- `y_valid`  out  1  `y` holds an untaken result.
- `y_ready`  in  1  consumer accepts `y`.
- `overrun`  out  1  sticky overrun flag; present only with `BITSTREAM_DECODER_OVERRUN_EN`.

## Operation
- Reset (asynchronous, takes effect immediately):
  - `y`=0, `y_valid`=0, `overrun`=0.
  - Internal `sample_cnt`=0 (WIDTH bits) and `ones_cnt`=0 (WIDTH+1 bits).
- Each edge with `en`=1:
  - `sample_cnt` increments, wrapping modulo 2^WIDTH.
  - `ones_cnt` increments when `x`=1.
- Edges with `en`=0: no counter changes.
- Window completion: an edge with `en`=1 and `sample_cnt`=2^WIDTH−1.
  - The result is `ones_cnt + x`.
  - `ones_cnt` clears to 0 and `sample_cnt` wraps to 0; the next window starts on the following sample with no gap.
- Output register FSM, states EMPTY (`y_valid`=0) and FULL (`y_valid`=1):
  - EMPTY, completion: load `y`, go to FULL.
  - FULL, `y_ready`=1, no completion: go to EMPTY; `y` keeps its stale value.
  - FULL, `y_ready`=1, completion on the same edge: load the new `y`, stay FULL. This counts as a transfer plus a load, not an overrun.
  - FULL, `y_ready`=0, completion: overrun.
    - The new result is discarded and `y` keeps the old result.
    - `overrun` is set if the macro is compiled in.
  - `y_ready` while EMPTY is ignored.
- `y` never changes while `y_valid`=1 and `y_ready`=0.
- Reset asserted mid-window discards the partial window and any pending result.

## Timing
- Latency: `y`/`y_valid` update on the edge that samples the final bit of a window. No combinational path from `x` or `en` to the outputs.
- A transfer occurs on an edge where `y_valid`=1 and `y_ready`=1.
- Maximum result rate: one per 2^WIDTH `en` cycles.
- `overrun`, when compiled in, stays high until reset.

## Configuration
- `BITSTREAM_DECODER_OVERRUN_EN` defined:
  - The `overrun` port and its sticky register exist.
  - The flag is set on the first dropped result.
- Undefined:
  - The port is absent.
  - Dropped results are silent; datapath and FSM behaviour are otherwise identical.

## Structure
- Shared package `bitstream_pkg`:
  - output FSM enum `out_state_t` {EMPTY, FULL};
  - default window width constant `BS_WINDOW_W` = 8.
- Natural sub-module `window_counter`:
  - holds `sample_cnt`/`ones_cnt`;
  - emits a one-cycle `done` strobe and `count` (WIDTH+1);
  - the top level holds only the output FSM and register.

## Test plan
All scenarios use WIDTH=4 (16-sample windows).
- Reset: apply `rst`, then release → `y`=0, `y_valid`=0 for 20 idle cycles with `en`=0.
- `x`=1 for 16 `en` cycles, `y_ready`=1 → `y`=16, `y_valid`=1 for exactly one cycle after the 16th sample edge.
- Alternating `x` with `en` high every other cycle (32 cycles total) → `y`=8 only after 16 qualified samples.
- Two back-to-back windows (all ones, then all zeros), `y_ready`=1 → `y`=16 then `y`=0, each with a one-cycle `y_valid`.
- `y_ready`=0 across two windows (5 ones, then 9 ones) → `y` stays 5, `y_valid` stays 1; `overrun`=1 after the second completion if the macro is defined.
- `rst` pulsed after 10 samples, then 16 samples of `x`=1 → `y`=16; the partial window does not contribute.
